sti_dac_gen: RTL and testbench

//  Parametrised serial transmitter plus pixel-memory writer; successor to the fixed 16/8-bit STI/DAC block.

---
 rtl/sti_dac_gen.sv | 166 ++++++++++++++++
 tb/tb_sti_dac_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sti_dac_gen.sv
// Parametrised serial transmitter that packs the emitted bit stream into PIX_W-bit pixel RAM writes.
// Optional odd-parity trailer bit per word when STI_DAC_PARITY_EN is defined.
module sti_dac_gen #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [2*PIX_W-1:0]   pi_data,
  input  logic [1:0]           pi_length,
  input  logic                 pi_fill,
  input  logic                 pi_msb,
  input  logic                 pi_low,
  input  logic                 pi_end,
  output logic                 pi_ready,
  output logic                 so_data,
  output logic                 so_valid,
  output logic                 pixel_wr,
  output logic [ADDR_W-1:0]    pixel_addr,
  output logic [PIX_W-1:0]     pixel_dataout,
  output logic                 pixel_finish
);
  localparam int IN_W = 2*PIX_W;
  localparam int FW   = 4*PIX_W;
  localparam int CW   = $clog2(FW+1);
  localparam int IW   = $clog2(FW);
  localparam int PW   = $clog2(PIX_W);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     frame_q, frame_d, frame_n;
  logic [CW-1:0]     n_q, n_d, cnt_q, cnt_d;
  logic              msb_q, msb_d, end_q, end_d;
  logic [PW-1:0]     pb_q, pb_d;
  logic [PIX_W-1:0]  pix_q, pix_d, dout_q, dout_d;
  logic              wr_q, wr_d, fin_q, fin_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IW-1:0]     ix;
  logic              bit_sel, so_bit, par_cyc, last, stop;

  always_comb begin
    frame_n = FW'(pi_data);
    case (pi_length)
      2'd0:    frame_n = FW'(pi_low ? pi_data[IN_W-1:PIX_W] : pi_data[PIX_W-1:0]);
      2'd2:    frame_n = pi_fill ? FW'({pi_data, {PIX_W{1'b0}}}) : FW'(pi_data);
      2'd3:    frame_n = pi_fill ? {pi_data, {IN_W{1'b0}}} : FW'(pi_data);
      default: frame_n = FW'(pi_data);
    endcase
  end

  always_comb begin
    ix      = msb_q ? IW'(n_q - CW'(1) - cnt_q) : IW'(cnt_q);
    bit_sel = frame_q[ix];
`ifdef STI_DAC_PARITY_EN
    // Frame bits above N are zero, so reducing the whole register is safe.
    par_cyc = (cnt_q == n_q);
    last    = par_cyc;
    so_bit  = par_cyc ? ~^frame_q : bit_sel;
`else
    par_cyc = 1'b0;
    last    = (cnt_q == n_q - CW'(1));
    so_bit  = bit_sel;
`endif
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    msb_d   = msb_q;
    end_d   = end_q;
    pb_d    = pb_q;
    pix_d   = pix_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    fin_d   = fin_q;
    wr_d    = 1'b0;
    stop    = fin_q || (wr_q && addr_q == ADDR_W'(DEPTH-1));
    // Address advances after each completed write; the last address latches finish instead.
    if (wr_q) begin
      if (addr_q == ADDR_W'(DEPTH-1)) fin_d = 1'b1;
      else                            addr_d = addr_q + ADDR_W'(1);
    end
    case (state_q)
      IDLE: if (load) begin
        frame_d = frame_n;
        n_d     = CW'((32'(pi_length) + 1) * PIX_W);
        msb_d   = pi_msb;
        end_d   = pi_end;
        cnt_d   = '0;
        pb_d    = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (!par_cyc) begin
          pix_d = {pix_q[PIX_W-2:0], bit_sel};
          if (pb_q == PW'(PIX_W-1)) begin
            pb_d = '0;
            if (!stop) begin
              wr_d   = 1'b1;
              dout_d = pix_d;
            end
          end else begin
            pb_d = pb_q + PW'(1);
          end
        end
        if (last) begin
          if (end_q) state_d = (!wr_d && fin_d) ? DONE : FLUSH;
          else       state_d = IDLE;
        end
      end
      FLUSH: begin
        if (fin_d) state_d = DONE;
        else begin
          wr_d   = 1'b1;
          dout_d = '0;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
      end_q   <= 1'b0;
      pb_q    <= '0;
      pix_q   <= '0;
      dout_q  <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
      end_q   <= end_d;
      pb_q    <= pb_d;
      pix_q   <= pix_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      fin_q   <= fin_d;
    end
  end

  assign pi_ready      = (state_q == IDLE);
  assign so_valid      = (state_q == SHIFT);
  assign so_data       = so_valid & so_bit;
  assign pixel_wr      = wr_q;
  assign pixel_addr    = addr_q;
  assign pixel_dataout = dout_q;
  assign pixel_finish  = fin_q;
endmodule

// File: tb/tb_sti_dac_gen.sv
// Scoreboard bench for sti_dac_gen: directed words push expected serial bits and pixel writes,
// a monitor pops and compares whenever so_valid or pixel_wr is seen.
module tb_sti_dac_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] pi_data = '0;
  logic [1:0]  pi_length = '0;
  logic        pi_fill = 1'b0, pi_msb = 1'b0, pi_low = 1'b0, pi_end = 1'b0;
  logic        pi_ready, so_data, so_valid, pixel_wr, pixel_finish;
  logic [8:0]  pixel_addr;
  logic [7:0]  pixel_dataout;

  typedef struct { logic [8:0] a; logic [7:0] d; } pix_t;
  logic so_exp[$];
  pix_t px_exp[$];
  int   vectors = 0;
  int   miscompares = 0;

  sti_dac_gen dut (
    .clk(clk), .reset(reset), .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .pi_ready(pi_ready), .so_data(so_data), .so_valid(so_valid), .pixel_wr(pixel_wr),
    .pixel_addr(pixel_addr), .pixel_dataout(pixel_dataout), .pixel_finish(pixel_finish)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic b;
    pix_t p;
    #1;
    if (so_valid) begin
      if (so_exp.size() == 0) chk("so_unexpected", 32'(so_valid), 0);
      else begin
        b = so_exp.pop_front();
        chk("so_data", 32'(so_data), 32'(b));
      end
    end
    if (pixel_wr) begin
      if (px_exp.size() == 0) chk("pixel_unexpected", 32'(pixel_wr), 0);
      else begin
        p = px_exp.pop_front();
        chk("pixel_addr", 32'(pixel_addr), 32'(p.a));
        chk("pixel_data", 32'(pixel_dataout), 32'(p.d));
      end
    end
  end

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n-1; i >= 0; i--) so_exp.push_back(v[i]);
  endtask

  task automatic push_pix(input int a, input logic [7:0] d);
    pix_t p;
    p.a = 9'(a);
    p.d = d;
    px_exp.push_back(p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    so_exp.delete();
    px_exp.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] len, input logic fill,
                      input logic msb, input logic low, input logic e);
    int t = 0;
    @(negedge clk);
    while (!pi_ready && t < 200) begin @(negedge clk); t++; end
    if (!pi_ready) chk("ready_timeout", 32'(pi_ready), 1);
    load = 1'b1; pi_data = d; pi_length = len; pi_fill = fill;
    pi_msb = msb; pi_low = low; pi_end = e;
    @(negedge clk);
    load = 1'b0; pi_end = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((so_exp.size() != 0 || px_exp.size() != 0) && t < 3000) begin
      @(negedge clk); t++;
    end
    chk("drain_so", 32'(so_exp.size()), 0);
    chk("drain_px", 32'(px_exp.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int lowcnt;
    int t;
    repeat (3) @(negedge clk);
    chk("rst_so_valid", 32'(so_valid), 0);
    chk("rst_pixel_wr", 32'(pixel_wr), 0);
    chk("rst_addr", 32'(pixel_addr), 0);
    chk("rst_finish", 32'(pixel_finish), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(pi_ready), 1);

    // len0, upper half, MSB first
    push_bits(32'hA5, 8); push_pix(0, 8'hA5);
    send(16'hA53C, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();

    // len1, LSB first
    do_reset();
    push_bits(32'h8000, 16); push_pix(0, 8'h80); push_pix(1, 8'h00);
    send(16'h0001, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // len3, fill to MSBs
    do_reset();
    push_bits(32'hFFFF0000, 32);
    push_pix(0, 8'hFF); push_pix(1, 8'hFF); push_pix(2, 8'h00); push_pix(3, 8'h00);
    send(16'hFFFF, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    // load held high through the whole word: only one acceptance
    do_reset();
    push_bits(32'hC0DE, 16); push_pix(0, 8'hC0); push_pix(1, 8'hDE);
    @(negedge clk);
    load = 1'b1; pi_data = 16'hC0DE; pi_length = 2'd1; pi_msb = 1'b1; pi_fill = 1'b0;
    lowcnt = 0;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (!pi_ready) lowcnt++;
    end
    load = 1'b0;
    chk("ready_low_cycles", 32'(lowcnt), 16);
    drain();

    // two words, second is last: flush zeros to the end of the frame
    do_reset();
    push_bits(32'hC3, 8); push_pix(0, 8'hC3);
    send(16'h77C3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_bits(32'h48, 8); push_pix(1, 8'h48);
    for (int a = 2; a < 256; a++) push_pix(a, 8'h00);
    send(16'h1299, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    t = 0;
    while (!(pixel_wr && pixel_addr == 9'd255) && t < 600) begin @(negedge clk); t++; end
    chk("flush_reach_255", 32'(pixel_addr), 255);
    chk("finish_before_last", 32'(pixel_finish), 0);
    @(negedge clk);
    chk("finish_after_last", 32'(pixel_finish), 1);
    chk("done_ready", 32'(pi_ready), 0);
    load = 1'b1; pi_length = 2'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("done_so_valid", 32'(so_valid), 0);
      chk("done_pixel_wr", 32'(pixel_wr), 0);
      chk("done_finish", 32'(pixel_finish), 1);
    end
    load = 1'b0;
    drain();

    // reset mid-flush, then a fresh frame restarts at address 0
    do_reset();
    push_bits(32'hFF, 8); push_pix(0, 8'hFF);
    for (int a = 1; a < 256; a++) push_pix(a, 8'h00);
    send(16'h00FF, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    t = 0;
    while (pixel_addr != 9'd100 && t < 400) begin @(negedge clk); t++; end
    chk("flush_reach_100", 32'(pixel_addr), 100);
    reset = 1'b0;
    px_exp.delete();
    @(posedge clk); #2;
    chk("midrst_so_valid", 32'(so_valid), 0);
    chk("midrst_pixel_wr", 32'(pixel_wr), 0);
    chk("midrst_addr", 32'(pixel_addr), 0);
    chk("midrst_data", 32'(pixel_dataout), 0);
    chk("midrst_finish", 32'(pixel_finish), 0);
    chk("midrst_ready", 32'(pi_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    push_bits(32'h5A, 8); push_pix(0, 8'h5A);
    send(16'h5A00, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();

    // address wrap without pi_end: finish rises, later words serialise without writes
    do_reset();
    for (int i = 0; i < 128; i++) begin
      push_bits({16'h0, 8'(i), ~8'(i)}, 16);
      push_pix(2*i, 8'(i)); push_pix(2*i+1, ~8'(i));
      send({8'(i), ~8'(i)}, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    drain();
    chk("wrap_finish", 32'(pixel_finish), 1);
    chk("wrap_addr", 32'(pixel_addr), 255);
    push_bits(32'h96, 8);
    send(16'h0096, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    chk("wrap_addr_hold", 32'(pixel_addr), 255);
    chk("wrap_ready", 32'(pi_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
